// File: rtl/sumador_pkg.sv
// Shared definitions for the serial add/subtract unit: FSM state encoding
// and the counter-width helper.
package sumador_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // $clog2 returns 0 for a single-digit operation; a counter needs at least one bit
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sumador_digito.sv
// Combinational ripple of DIGIT full adders; also exposes the carry into the
// top bit so the caller can form signed overflow.
module sumador_digito #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             c_in,
   output logic [DIGIT-1:0] s,
   output logic             c_out,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   assign c[0] = c_in;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign c_out    = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/sumador_serie_n.sv
// Multi-cycle add/subtract: consumes DIGIT bits of the operands per clock
// through one digit adder, with a start/ready/done handshake.
module sumador_serie_n
   import sumador_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = clog2_min1(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_nxt;
   logic             carry;
   logic             accept;
   logic [DIGIT-1:0] dig_s;
   logic             dig_c;
   logic             dig_cmsb;

   assign accept = start & ready;

   sumador_digito #(.DIGIT(DIGIT)) u_digito (
      .a        (a_sr[DIGIT-1:0]),
      .b        (b_sr[DIGIT-1:0]),
      .c_in     (carry),
      .s        (dig_s),
      .c_out    (dig_c),
      .c_msb_in (dig_cmsb)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and handshake outputs; a start in DONE chains straight into RUN
   always_comb begin
      state_nxt = state;
      ready     = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_LAST) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            ready     = 1'b1;
            done      = 1'b1;
            state_nxt = start ? ST_RUN : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Earlier digits are collected in a shift register; the newest digit enters at the top
   if (N > 1) begin : g_multi
      logic [WIDTH-DIGIT-1:0] res_sr;

      always_ff @(posedge clk) begin
         if (rst) begin
            res_sr <= '0;
         end else if (state == ST_RUN) begin
            res_sr <= res_nxt[WIDTH-1:DIGIT];
         end
      end

      assign res_nxt = {dig_s, res_sr};
   end else begin : g_single
      assign res_nxt = dig_s;
   end

   // Subtraction is a + ~b with the carry seed inverted, so the adder never changes
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         c_out <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_sr  <= a;
         b_sr  <= b ^ {WIDTH{sub}};
         carry <= c_in ^ sub;
         cnt   <= '0;
      end else if (state == ST_RUN) begin
         a_sr  <= a_sr >> DIGIT;
         b_sr  <= b_sr >> DIGIT;
         carry <= dig_c;
         cnt   <= cnt + 1'b1;
         if (cnt == CNT_LAST) begin
            sum   <= res_nxt;
            c_out <= dig_c;
            ovf   <= dig_c ^ dig_cmsb;
         end
      end
   end

endmodule

// File: tb/tb_sumador_serie_n.sv
// Scoreboard bench for sumador_serie_n: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_sumador_serie_n;

   localparam int WIDTH = 16;
   localparam int DIGIT = 4;
   localparam int N     = WIDTH / DIGIT;

   typedef struct {
      logic [15:0] sum;
      logic        cOut;
      logic        ovf;
      int          doneCyc;
      int          id;
   } expect_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sub;
   logic        cIn;
   logic [15:0] opA;
   logic [15:0] opB;
   logic        ready;
   logic        done;
   logic [15:0] sum;
   logic        cOut;
   logic        ovf;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;
   int      cyc    = 0;
   int      opId   = 0;

   sumador_serie_n #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (opA),
      .b     (opB),
      .c_in  (cIn),
      .ready (ready),
      .done  (done),
      .sum   (sum),
      .c_out (cOut),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   // Every done must match the oldest outstanding operation, including its cycle
   always @(negedge clk) begin
      expect_t e;
      if (done !== 1'b0) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_done actual=%b required=0 cyc=%0d", done, cyc);
         end else begin
            e = expQ.pop_front();
            checkOutput($sformatf("op%0d_sum", e.id), 32'(sum), 32'(e.sum));
            checkOutput($sformatf("op%0d_c_out", e.id), 32'(cOut), 32'(e.cOut));
            checkOutput($sformatf("op%0d_ovf", e.id), 32'(ovf), 32'(e.ovf));
            checkOutput($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.doneCyc));
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge with start low
   task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                input logic tcin, input logic tsub,
                                input logic [15:0] expSum, input logic expC, input logic expOvf);
      int      budget;
      expect_t e;
      budget = 0;
      while (ready !== 1'b1 && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout actual=%b required=1", ready);
         return;
      end
      opA   = ta;
      opB   = tb;
      cIn   = tcin;
      sub   = tsub;
      start = 1'b1;
      @(posedge clk);
      #1;
      opId++;
      e.sum     = expSum;
      e.cOut    = expC;
      e.ovf     = expOvf;
      e.doneCyc = cyc + N;
      e.id      = opId;
      expQ.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDrain();
      int budget;
      budget = 0;
      while (expQ.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain_timeout actual=%0d required=0", expQ.size());
         expQ.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      cIn   = 1'b0;
      opA   = '0;
      opB   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_sum", 32'(sum), 32'd0);
      checkOutput("reset_c_out", 32'(cOut), 32'd0);
      checkOutput("reset_ovf", 32'(ovf), 32'd0);
      rst = 1'b0;

      // Single operation from idle
      applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      waitDrain();

      // Back-to-back chain: each op is accepted in the previous op's done cycle
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
      applyStimulus(16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0);
      applyStimulus(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      waitDrain();

      // A start pulse during RUN must be ignored
      applyStimulus(16'h1000, 16'h0234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0);
      opA   = 16'hFFFF;
      opB   = 16'hFFFF;
      sub   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitDrain();
      repeat (3) @(negedge clk);
      checkOutput("hold_sum", 32'(sum), 32'h1234);
      checkOutput("hold_ready", 32'(ready), 32'd1);

      // Reset in the second RUN cycle aborts the operation without a done
      applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_ready", 32'(ready), 32'd1);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_sum", 32'(sum), 32'd0);
      repeat (N + 3) @(negedge clk);

      // Normal operation resumes after the abort
      applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
